// File: rtl/uart_digit_scroller_pkg.sv
// Shared constants, state encodings and byte classification for the UART digit scroller.
package uart_digit_scroller_pkg;

    localparam logic [3:0] BLANK    = 4'hF;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SCROLL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CH_OTHER = 2'd0,
        CH_DIG   = 2'd1,
        CH_SP    = 2'd2,
        CH_TERM  = 2'd3
    } char_cls_t;

    function automatic char_cls_t char_class(input logic [7:0] b);
        if (b >= ASCII_0 && b <= ASCII_9) return CH_DIG;
        if (b == ASCII_SP)                return CH_SP;
        if (b == ASCII_CR || b == ASCII_LF) return CH_TERM;
        return CH_OTHER;
    endfunction

    function automatic logic [3:0] char_code(input logic [7:0] b);
        logic [7:0] d;
        d = b - ASCII_0;
        return (b == ASCII_SP) ? BLANK : d[3:0];
    endfunction

endpackage

// File: rtl/uart_digit_scroller_if.sv
// Received-byte strobe bus from the UART RX into the digit scroller.
interface uart_digit_scroller_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/uart_digit_scroller_tick.sv
// scroll_tick_gen: free-running divider emitting a 1-cycle tick every TICK_DIV enabled cycles.
module scroll_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

    // clr dominates so a simultaneous restart never leaks a stale tick
    assign tick = en && !clr && (r_cnt == LAST);
endmodule

// File: rtl/uart_digit_scroller.sv
// Stores a numeric UART message and scrolls it across six BCD digits (bcd5 leftmost).
// Optional freeze input enabled by defining UART_SCROLLER_PAUSE_EN.
module uart_digit_scroller
    import uart_digit_scroller_pkg::*;
#(
    parameter int TICK_DIV  = 12_500_000,
    parameter int MSG_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_digit_scroller_if.slave  rx,
`ifdef UART_SCROLLER_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [3:0]            bcd5,
    output logic [3:0]            bcd4,
    output logic [3:0]            bcd3,
    output logic [3:0]            bcd2,
    output logic [3:0]            bcd1,
    output logic [3:0]            bcd0,
    output logic                  scrolling,
    output logic                  overflow
);
    localparam int            PW    = $clog2(MSG_DEPTH + 7);
    localparam int            SW    = PW + 1;  // holds pos+5 without wrapping
    localparam int            AW    = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam logic [PW-1:0] DEPTH = PW'(MSG_DEPTH);

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_len, w_len_nxt;
    logic [PW-1:0] r_pos, w_pos_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;
    logic [3:0]    r_buf [MSG_DEPTH];
    logic [3:0]    r_bcd [6];
    logic [3:0]    w_win [6];
    logic [SW-1:0] w_idx [6];
    logic [SW-1:0] w_n;
    char_cls_t     w_cls;
    logic [3:0]    w_code;
    logic          w_acc, w_term, w_tick, w_run, w_tick_en, w_tick_clr;

    assign w_cls  = char_class(rx.rx_data);
    assign w_code = char_code(rx.rx_data);
    assign w_acc  = rx.rx_valid && (w_cls == CH_DIG || w_cls == CH_SP);
    assign w_term = rx.rx_valid && (w_cls == CH_TERM);

`ifdef UART_SCROLLER_PAUSE_EN
    assign w_run = !pause;
`else
    assign w_run = 1'b1;
`endif

    assign w_tick_en  = (r_state == SCROLL) && w_run;
    assign w_tick_clr = (r_state != SCROLL) || w_acc;

    scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_tick_clr),
        .en    (w_tick_en),
        .tick  (w_tick)
    );

    // Window over message followed by six virtual blanks
    assign w_n = SW'(r_len) + SW'(6);
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_idx[i] = SW'(r_pos) + SW'(i);
            if (w_idx[i] >= w_n)
                w_idx[i] = w_idx[i] - w_n;
            w_win[5-i] = (w_idx[i] < SW'(r_len)) ? r_buf[w_idx[i][AW-1:0]] : BLANK;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_pos_nxt   = r_pos;
        w_ovf_nxt   = r_ovf;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_len;
        case (r_state)
            LOAD: begin
                if (w_acc) begin
                    if (r_len == DEPTH) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_len_nxt = r_len + 1'b1;
                    end
                end else if (w_term) begin
                    w_state_nxt = SCROLL;
                    w_pos_nxt   = '0;
                end
            end
            IDLE, SCROLL: begin
                if (w_acc) begin
                    w_state_nxt = LOAD;
                    w_wr_en     = 1'b1;
                    w_wr_idx    = '0;
                    w_len_nxt   = PW'(1);
                    w_ovf_nxt   = 1'b0;
                end else if (r_state == SCROLL && w_tick) begin
                    w_pos_nxt = (r_pos == r_len + PW'(5)) ? '0 : r_pos + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_pos   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_pos   <= w_pos_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_buf[w_wr_idx[AW-1:0]] <= w_code;
    end

    // Blank on entry and on abort; otherwise show the window for the current pos
    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (!rst_n)
                r_bcd[i] <= BLANK;
            else
                r_bcd[i] <= (r_state == SCROLL && w_state_nxt == SCROLL) ? w_win[i] : BLANK;
        end
    end

    assign bcd5      = r_bcd[5];
    assign bcd4      = r_bcd[4];
    assign bcd3      = r_bcd[3];
    assign bcd2      = r_bcd[2];
    assign bcd1      = r_bcd[1];
    assign bcd0      = r_bcd[0];
    assign scrolling = (r_state == SCROLL);
    assign overflow  = r_ovf;
endmodule
